// File: rtl/irq_ctrl_ahb.sv
// Multi-source interrupt controller with an AHB-Lite slave port.
// Sticky status bits latch event pulses, a software enable mask gates them
// onto a single registered IRQ line, and a CLAIM register hands out the
// lowest-numbered pending source while clearing it.
module irq_ctrl_ahb #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ahb_hsel,
    input  logic [31:0]      ahb_haddr,
    input  logic [1:0]       ahb_hsize,
    input  logic [1:0]       ahb_htrans,
    input  logic [31:0]      ahb_hwdata,
    input  logic             ahb_hwrite,
    output logic [31:0]      ahb_hrdata,
    output logic             ahb_hresp,
    output logic             ahb_hready,
    input  logic [N_SRC-1:0] irq_src,
    output logic             irq_out
);

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_ENABLE = 2'd1;
    localparam logic [1:0] REG_CLEAR  = 2'd2;
    localparam logic [1:0] REG_CLAIM  = 2'd3;

    // Lowest set index of a pending vector; 0 when nothing is set.
    function automatic logic [4:0] lowest_idx(input logic [N_SRC-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    logic             ap_valid;
    logic             ap_write;
    logic [1:0]       ap_reg;
    logic [N_SRC-1:0] status;
    logic [N_SRC-1:0] enable;
    logic             claim_valid;
    logic [4:0]       claim_id;

    logic             addr_valid;
    logic             dp_write_clear;
    logic             dp_write_enable;
    logic             dp_read_claim;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] status_next;
    logic [N_SRC-1:0] enable_next;
    logic [N_SRC-1:0] pend;
    logic             unused_ok;

    assign ahb_hresp  = 1'b0;
    assign ahb_hready = 1'b1;

    // Transfer size and undecoded address/data bits carry no meaning here.
    assign unused_ok = ^{ahb_hsize, ahb_haddr[31:4], ahb_haddr[1:0], ahb_hwdata};

    assign addr_valid      = ahb_hsel & ahb_htrans[1];
    assign dp_write_clear  = ap_valid &  ap_write & (ap_reg == REG_CLEAR);
    assign dp_write_enable = ap_valid &  ap_write & (ap_reg == REG_ENABLE);
    assign dp_read_claim   = ap_valid & ~ap_write & (ap_reg == REG_CLAIM);

    // Bits cleared at the coming edge: W1C data plus the claimed source.
    always_comb begin
        clr = '0;
        if (dp_write_clear) clr = ahb_hwdata[N_SRC-1:0];
        for (int i = 0; i < N_SRC; i++) begin
            if (dp_read_claim && claim_valid && (claim_id == 5'(i))) clr[i] = 1'b1;
        end
    end

    // A new pulse beats a simultaneous clear. The claim snapshot drops bits
    // being cleared this cycle so back-to-back claims never repeat an id.
    assign status_next = irq_src | (status & ~clr);
    assign enable_next = dp_write_enable ? ahb_hwdata[N_SRC-1:0] : enable;
    assign pend        = status & ~clr & enable;

    // Address-phase capture, interrupt state and claim snapshot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ap_valid    <= 1'b0;
            ap_write    <= 1'b0;
            ap_reg      <= '0;
            status      <= '0;
            enable      <= '0;
            irq_out     <= 1'b0;
            claim_valid <= 1'b0;
            claim_id    <= '0;
        end else begin
            ap_valid <= addr_valid;
            ap_write <= addr_valid & ahb_hwrite;
            ap_reg   <= addr_valid ? ahb_haddr[3:2] : 2'd0;
            status   <= status_next;
            enable   <= enable_next;
            irq_out  <= |(status_next & enable_next);
            if (addr_valid && !ahb_hwrite && (ahb_haddr[3:2] == REG_CLAIM)) begin
                claim_valid <= |pend;
                claim_id    <= lowest_idx(pend);
            end
        end
    end

    // Data-phase read mux; zero for idle cycles and writes.
    always_comb begin
        ahb_hrdata = '0;
        if (ap_valid && !ap_write) begin
            case (ap_reg)
                REG_STATUS: ahb_hrdata = 32'(status);
                REG_ENABLE: ahb_hrdata = 32'(enable);
                REG_CLEAR:  ahb_hrdata = '0;
                default:    ahb_hrdata = {claim_valid, 26'b0, claim_id};
            endcase
        end
    end

endmodule
